// File: rtl/keypad_scan_decoder_pkg.sv
// keypad_pkg: shared state/class encodings, code constants and key-code mapping
package keypad_pkg;

    typedef enum logic [1:0] {S_IDLE, S_DEBOUNCE, S_PRESSED, S_RELEASE} state_t;
    typedef enum logic [1:0] {CL_NONE, CL_SINGLE, CL_MULTI} class_t;

    localparam int NO_KEY_DEF = 41;
    localparam int STAR       = 10;
    localparam int HASH       = 11;

    // r counts rows from the top, c counts columns from the left
    function automatic int code_of(input int r, input int c, input int cols, input bit phone);
        if (!phone) return r * cols + c;
        if (r < 3) return r * 3 + c + 1;
        return (c == 0) ? STAR : ((c == 1) ? 0 : HASH);
    endfunction

endpackage

// File: rtl/keypad_scan_decoder_if.sv
// keypad_scan_decoder_if: keypad lines and decoded key outputs
interface keypad_scan_decoder_if #(
    parameter int ROWS   = 4,
    parameter int COLS   = 3,
    parameter int CODE_W = 6
);
    logic [ROWS-1:0]   filas;
    logic [COLS-1:0]   columnas;
    logic [CODE_W-1:0] num;
    logic              key_valid;
    logic              key_release;
    logic              key_held;
    logic              multi_key;

    modport master (input filas, output columnas, num, key_valid, key_release, key_held, multi_key);
    modport slave  (output filas, input columnas, num, key_valid, key_release, key_held, multi_key);
endinterface

// File: rtl/keypad_scan_decoder_col_scanner.sv
// keypad_col_scanner: column ring with per-slot sample and end-of-frame strobes
module keypad_col_scanner #(
    parameter int COLS     = 3,
    parameter int SCAN_DIV = 4,
    localparam int CI_W    = (COLS > 1) ? $clog2(COLS) : 1,
    localparam int SL_W    = $clog2(SCAN_DIV)
) (
    input  logic            clk1k,
    input  logic            rst,
    output logic [COLS-1:0] o_columnas,
    output logic [CI_W-1:0] o_col,
    output logic            o_sample,
    output logic            o_frame_end
);
    localparam logic [COLS-1:0] LEFT = 1 << (COLS - 1);

    logic [SL_W-1:0] r_slot;
    logic [CI_W-1:0] r_col;

    // advance the slot counter; step to the next column when a slot completes
    always_ff @(posedge clk1k or posedge rst) begin
        if (rst) begin
            r_slot <= '0;
            r_col  <= '0;
        end else if (o_sample) begin
            r_slot <= '0;
            r_col  <= (r_col == CI_W'(COLS - 1)) ? '0 : r_col + CI_W'(1);
        end else begin
            r_slot <= r_slot + SL_W'(1);
        end
    end

    assign o_sample    = r_slot == SL_W'(SCAN_DIV - 1);
    assign o_frame_end = o_sample && r_col == CI_W'(COLS - 1);
    assign o_col       = r_col;
    assign o_columnas  = LEFT >> r_col;

endmodule

// File: rtl/keypad_scan_decoder.sv
// keypad_scan_decoder: scans the matrix, debounces whole frames and emits key codes
module keypad_scan_decoder
    import keypad_pkg::*;
#(
    parameter int ROWS      = 4,
    parameter int COLS      = 3,
    parameter int SCAN_DIV  = 4,
    parameter int DEBOUNCE  = 3,
    parameter int CODE_W    = 6,
    parameter int NO_KEY    = NO_KEY_DEF,
    parameter bit PHONE_MAP = 1'b1
) (
    input logic            clk1k,
    input logic            rst,
    keypad_scan_decoder_if.master bus
);
    localparam int CI_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RI_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CN_W = $clog2(DEBOUNCE + 1);

    logic [CI_W-1:0]            w_col;
    logic                       w_sample;
    logic                       w_frame_end;
    logic [ROWS-1:0]            r_sync1, r_sync2;
    logic [COLS-1:0][ROWS-1:0]  r_img;
    logic [COLS-1:0][ROWS-1:0]  w_frame;
    logic                       w_any, w_many;
    logic [RI_W-1:0]            w_kr, r_cand_r, w_cand_r_nx;
    logic [CI_W-1:0]            w_kc, r_cand_c, w_cand_c_nx;
    class_t                     w_class;
    state_t                     r_state, w_state_nx;
    logic [CN_W-1:0]            r_cnt, w_cnt_nx;
    logic                       w_same, w_last, w_acc_p, w_acc_r;
    logic [CODE_W-1:0]          r_num, w_code;
    logic                       r_key_valid, r_key_release, r_multi;

    keypad_col_scanner #(.COLS(COLS), .SCAN_DIV(SCAN_DIV)) u_scan (
        .clk1k       (clk1k),
        .rst         (rst),
        .o_columnas  (bus.columnas),
        .o_col       (w_col),
        .o_sample    (w_sample),
        .o_frame_end (w_frame_end)
    );

    // two-flop row synchroniser and per-column frame image
    always_ff @(posedge clk1k or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_img   <= '0;
        end else begin
            r_sync1 <= bus.filas;
            r_sync2 <= r_sync1;
            if (w_sample) r_img[w_col] <= r_sync2;
        end
    end

    // classify the frame, splicing in the column being sampled this cycle
    always_comb begin
        w_any  = 1'b0;
        w_many = 1'b0;
        w_kr   = '0;
        w_kc   = '0;
        for (int c = 0; c < COLS; c++) begin
            w_frame[c] = (CI_W'(c) == w_col) ? r_sync2 : r_img[c];
            for (int b = 0; b < ROWS; b++) begin
                if (w_frame[c][b]) begin
                    w_many = w_many | w_any;
                    w_any  = 1'b1;
                    w_kr   = RI_W'(ROWS - 1 - b);
                    w_kc   = CI_W'(c);
                end
            end
        end
        w_class = w_many ? CL_MULTI : (w_any ? CL_SINGLE : CL_NONE);
    end

    assign w_same = w_class == CL_SINGLE && w_kr == r_cand_r && w_kc == r_cand_c;
    assign w_last = int'(r_cnt) + 1 >= DEBOUNCE;
    assign w_code = CODE_W'(code_of(int'(w_kr), int'(w_kc), COLS, PHONE_MAP));

    // debounce FSM next state, evaluated only on frame boundaries
    always_comb begin
        w_state_nx  = r_state;
        w_cnt_nx    = r_cnt;
        w_cand_r_nx = r_cand_r;
        w_cand_c_nx = r_cand_c;
        w_acc_p     = 1'b0;
        w_acc_r     = 1'b0;
        if (w_frame_end) begin
            case (r_state)
                S_IDLE: if (w_class == CL_SINGLE) begin
                    w_cand_r_nx = w_kr;
                    w_cand_c_nx = w_kc;
                    w_cnt_nx    = CN_W'(1);
                    w_state_nx  = (DEBOUNCE == 1) ? S_PRESSED : S_DEBOUNCE;
                    w_acc_p     = DEBOUNCE == 1;
                end
                S_DEBOUNCE: if (!w_same) begin
                    w_state_nx = S_IDLE;
                end else if (w_last) begin
                    w_state_nx = S_PRESSED;
                    w_acc_p    = 1'b1;
                end else begin
                    w_cnt_nx = r_cnt + CN_W'(1);
                end
                S_PRESSED: if (w_class == CL_NONE) begin
                    w_cnt_nx   = CN_W'(1);
                    w_state_nx = (DEBOUNCE == 1) ? S_IDLE : S_RELEASE;
                    w_acc_r    = DEBOUNCE == 1;
                end
                S_RELEASE: if (w_class != CL_NONE) begin
                    w_state_nx = S_PRESSED;
                    w_cnt_nx   = '0;
                end else if (w_last) begin
                    w_state_nx = S_IDLE;
                    w_acc_r    = 1'b1;
                end else begin
                    w_cnt_nx = r_cnt + CN_W'(1);
                end
                default: w_state_nx = S_IDLE;
            endcase
        end
    end

    // state, candidate and registered outputs; strobes last one cycle
    always_ff @(posedge clk1k or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_cand_r      <= '0;
            r_cand_c      <= '0;
            r_num         <= CODE_W'(NO_KEY);
            r_key_valid   <= 1'b0;
            r_key_release <= 1'b0;
            r_multi       <= 1'b0;
        end else begin
            r_state       <= w_state_nx;
            r_cnt         <= w_cnt_nx;
            r_cand_r      <= w_cand_r_nx;
            r_cand_c      <= w_cand_c_nx;
            r_key_valid   <= w_acc_p;
            r_key_release <= w_acc_r;
            r_multi       <= w_frame_end && w_class == CL_MULTI;
            if (w_acc_p) r_num <= w_code;
            else if (w_acc_r) r_num <= CODE_W'(NO_KEY);
        end
    end

    assign bus.num         = r_num;
    assign bus.key_valid   = r_key_valid;
    assign bus.key_release = r_key_release;
    assign bus.key_held    = r_state == S_PRESSED || r_state == S_RELEASE;
    assign bus.multi_key   = r_multi;

endmodule

// File: tb/tb_keypad_scan_decoder.sv
// tb_keypad_scan_decoder: directed keypad scenarios with a behavioural key matrix
module tb_keypad_scan_decoder;

    logic clk1k;
    logic rst;
    logic [2:0][3:0] pressed;
    int checks, errors;
    int nv, nr, nm, lv, lr, colbad, both;

    keypad_scan_decoder_if #(.ROWS(4), .COLS(3), .CODE_W(6)) bus ();

    keypad_scan_decoder u_dut (
        .clk1k (clk1k),
        .rst   (rst),
        .bus   (bus)
    );

    initial clk1k = 1'b0;
    always #5 clk1k = ~clk1k;

    always_comb begin
        bus.filas = '0;
        for (int c = 0; c < 3; c++)
            if (bus.columnas[2-c]) bus.filas = bus.filas | pressed[c];
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic run(input int frames);
        logic [2:0] exp_col;
        nv = 0; nr = 0; nm = 0; lv = 0; lr = 0; colbad = 0; both = 0;
        for (int i = 1; i <= frames * 12; i++) begin
            @(posedge clk1k);
            #1;
            exp_col = 3'b100 >> ((i % 12) / 4);
            if (bus.columnas !== exp_col) colbad++;
            if (bus.key_valid === 1'b1) begin nv++; lv = i; end
            if (bus.key_release === 1'b1) begin nr++; lr = i; end
            if (bus.multi_key === 1'b1) nm++;
            if (bus.key_valid === 1'b1 && bus.key_release === 1'b1) both++;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        pressed = '0;
        #12;
        chk("reset_columnas", int'(bus.columnas), 4);
        chk("reset_num", int'(bus.num), 41);
        chk("reset_held", int'(bus.key_held), 0);
        chk("reset_valid", int'(bus.key_valid), 0);
        @(negedge clk1k);
        rst = 1'b0;

        run(5);
        chk("idle_colscan", colbad, 0);
        chk("idle_valid", nv, 0);
        chk("idle_release", nr, 0);
        chk("idle_multi", nm, 0);
        chk("idle_num", int'(bus.num), 41);

        pressed[1][2] = 1'b1;
        run(4);
        chk("k5_valid_count", nv, 1);
        chk("k5_valid_cycle", lv, 36);
        chk("k5_num", int'(bus.num), 5);
        chk("k5_held", int'(bus.key_held), 1);
        chk("k5_colscan", colbad, 0);

        pressed = '0;
        run(4);
        chk("k5_rel_count", nr, 1);
        chk("k5_rel_cycle", lr, 36);
        chk("k5_rel_valid", nv, 0);
        chk("k5_rel_num", int'(bus.num), 41);
        chk("k5_rel_held", int'(bus.key_held), 0);

        pressed[1][1] = 1'b1;
        run(2);
        chk("k8_bounce1_valid", nv, 0);
        pressed = '0;
        run(1);
        chk("k8_gap_valid", nv, 0);
        chk("k8_gap_num", int'(bus.num), 41);
        pressed[1][1] = 1'b1;
        run(3);
        chk("k8_valid_count", nv, 1);
        chk("k8_valid_cycle", lv, 36);
        chk("k8_num", int'(bus.num), 8);
        pressed = '0;
        run(4);
        chk("k8_rel_count", nr, 1);
        chk("k8_rel_num", int'(bus.num), 41);

        pressed[0][3] = 1'b1;
        pressed[2][1] = 1'b1;
        run(3);
        chk("multi_pulses", nm, 3);
        chk("multi_valid", nv, 0);
        chk("multi_num", int'(bus.num), 41);
        chk("multi_held", int'(bus.key_held), 0);
        pressed = '0;
        pressed[2][0] = 1'b1;
        run(4);
        chk("hash_valid_count", nv, 1);
        chk("hash_num", int'(bus.num), 11);
        chk("hash_multi", nm, 0);
        pressed = '0;
        run(4);
        chk("hash_rel_num", int'(bus.num), 41);

        pressed[2][3] = 1'b1;
        run(4);
        chk("k3_num", int'(bus.num), 3);
        chk("k3_held", int'(bus.key_held), 1);
        #3;
        rst = 1'b1;
        #1;
        chk("k3_rst_num", int'(bus.num), 41);
        chk("k3_rst_held", int'(bus.key_held), 0);
        chk("k3_rst_columnas", int'(bus.columnas), 4);
        chk("k3_rst_release", int'(bus.key_release), 0);
        @(negedge clk1k);
        @(negedge clk1k);
        rst = 1'b0;
        run(4);
        chk("k3_again_valid", nv, 1);
        chk("k3_again_cycle", lv, 36);
        chk("k3_again_release", nr, 0);
        chk("k3_again_num", int'(bus.num), 3);
        chk("k3_again_both", both, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
